// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the cache refill path.
//               Holds the read-bridge FSM encoding and the AXI response and
//               protection encodings used on the memory side.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_ADDR,
    BR_DATA,
    BR_HOLD,
    BR_DONE
  } bridge_state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/cache_axi_read_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_read_bridge
// Description : Memory-side end of the cache refill interface. Takes a
//               single-word refill request, issues one AXI4-Lite read and
//               returns the word with a one-cycle rdy_o pulse. rdy_o never
//               arrives earlier than MIN_LATENCY cycles after the request,
//               and data_o is stable for a full cycle before and during rdy_o.
// Ports       : clk_i, rst_ni         - clock, asynchronous active-low reset
//               start_i, address_i    - refill request (sampled in IDLE only)
//               rdy_o, data_o, err_o  - refill completion, word and error flag
//               m_axi_ar*             - AXI4-Lite read address channel
//               m_axi_r*              - AXI4-Lite read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_read_bridge
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MIN_LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  output logic                  rdy_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int                 c_cnt_w     = $clog2(MIN_LATENCY + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(MIN_LATENCY);
  // The counter holds (cycle number - 1), so leaving HOLD when it reaches
  // MIN_LATENCY-2 puts DONE exactly in cycle MIN_LATENCY at the earliest.
  localparam logic [c_cnt_w-1:0] c_hold_exit = c_cnt_w'(MIN_LATENCY - 2);

  if (MIN_LATENCY < 4) begin : g_min_latency_check
    $fatal(1, "cache_axi_read_bridge: MIN_LATENCY must be >= 4");
  end

  bridge_state_t         state_q,   state_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  err_q,     err_d;
  logic [c_cnt_w-1:0]    elapsed_q, elapsed_d;

  // Word alignment drops the byte-offset bits of the request address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BR_IDLE;
      araddr_q  <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      elapsed_q <= elapsed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    data_d    = data_q;
    err_d     = err_q;
    elapsed_d = elapsed_q;

    // Saturating elapsed-cycle count while a request is in flight.
    if (elapsed_q != c_cnt_max) begin
      elapsed_d = elapsed_q + 1'b1;
    end

    case (state_q)
      BR_IDLE: begin
        elapsed_d = '0;
        if (start_i) begin
          araddr_d = {address_i[ADDR_WIDTH-1:2], 2'b00};
          state_d  = BR_ADDR;
        end
      end
      BR_ADDR: begin
        if (m_axi_arready) begin
          state_d = BR_DATA;
        end
      end
      BR_DATA: begin
        if (m_axi_rvalid) begin
          data_d  = m_axi_rdata;
          err_d   = (m_axi_rresp == AXI_RESP_SLVERR) ||
                    (m_axi_rresp == AXI_RESP_DECERR);
          state_d = BR_HOLD;
        end
      end
      BR_HOLD: begin
        if (elapsed_q >= c_hold_exit) begin
          state_d = BR_DONE;
        end
      end
      BR_DONE: begin
        state_d = BR_IDLE;
      end
      default: begin
        state_d = BR_IDLE;
      end
    endcase
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = AXI_PROT_DEFAULT;
  assign m_axi_arvalid = (state_q == BR_ADDR);
  assign m_axi_rready  = (state_q == BR_DATA);
  assign data_o        = data_q;
  assign rdy_o         = (state_q == BR_DONE);
  // The error flag is only meaningful alongside rdy_o; it stays low otherwise.
  assign err_o         = (state_q == BR_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_read_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_read_bridge
// Description : Self-checking bench. Two bridges (MIN_LATENCY 4 and 8) share
//               one scripted AXI slave. A transaction-level model derives the
//               expected outputs of every cycle from the request, the slave
//               delays and the latency rule rdy = max(t_r+2, MIN_LATENCY).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_read_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] address = '0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;

  logic        rdy4, err4, arv4, rr4;
  logic [31:0] data4, araddr4;
  logic [2:0]  prot4;
  logic        rdy8, err8, arv8, rr8;
  logic [31:0] data8, araddr8;
  logic [2:0]  prot8;

  cache_axi_read_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MIN_LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .address_i(address),
    .rdy_o(rdy4), .data_o(data4), .err_o(err4),
    .m_axi_araddr(araddr4), .m_axi_arprot(prot4), .m_axi_arvalid(arv4),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rr4)
  );

  cache_axi_read_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MIN_LATENCY(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .address_i(address),
    .rdy_o(rdy8), .data_o(data8), .err_o(err8),
    .m_axi_araddr(araddr8), .m_axi_arprot(prot8), .m_axi_arvalid(arv8),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rr8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction model: request parameters and the values held between requests.
  bit          txn_on    = 1'b0;
  bit          cmp_en    = 1'b0;
  int          t0 = 0, ta = 0, tbw = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [1:0]  m_resp = '0;
  logic [31:0] last_data = '0, last_addr = '0;

  // Per-transaction observations used by the literal checks.
  int          rdy_cnt4 = 0, rdy_cnt8 = 0, rdy_k4 = -1, rdy_k8 = -1;
  logic        rdy_err4 = 1'b0;
  int          ar_rise = 0, ar_cycles = 0, r_cycles = 0;
  logic        arv4_prev = 1'b0;
  logic [31:0] araddr_seen = '0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic check_dut(input string tag, input int m,
                           input logic rdy, input logic err, input logic arv, input logic rr,
                           input logic [31:0] dat, input logic [31:0] ara, input logic [2:0] prot);
    int k, tr, rk;
    bit in_ar, in_r, is_rdy, is_err;
    logic [31:0] e_data, e_addr;
    k  = cyc - t0;
    tr = 2 + ta + tbw;
    rk = (tr + 2 > m) ? tr + 2 : m;
    in_ar  = txn_on && k >= 1 && k <= 1 + ta;
    in_r   = txn_on && k >= 2 + ta && k <= tr;
    is_rdy = txn_on && k == rk;
    is_err = is_rdy && (m_resp == 2'b10 || m_resp == 2'b11);
    e_data = (txn_on && k >= tr + 1) ? m_data : last_data;
    e_addr = (txn_on && k >= 1) ? {m_addr[31:2], 2'b00} : last_addr;
    chk($sformatf("%s.arvalid", tag), 32'(arv), 32'(in_ar));
    chk($sformatf("%s.rready", tag), 32'(rr), 32'(in_r));
    chk($sformatf("%s.rdy", tag), 32'(rdy), 32'(is_rdy));
    chk($sformatf("%s.err", tag), 32'(err), 32'(is_err));
    chk($sformatf("%s.data", tag), dat, e_data);
    chk($sformatf("%s.araddr", tag), ara, e_addr);
    chk($sformatf("%s.arprot", tag), 32'(prot), 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut("m4", 4, rdy4, err4, arv4, rr4, data4, araddr4, prot4);
      check_dut("m8", 8, rdy8, err8, arv8, rr8, data8, araddr8, prot8);
      if (rdy4) begin rdy_cnt4++; rdy_k4 = cyc - t0; rdy_err4 = err4; end
      if (rdy8) begin rdy_cnt8++; rdy_k8 = cyc - t0; end
      if (arv4 && !arv4_prev) ar_rise++;
      if (arv4) begin ar_cycles++; araddr_seen = araddr4; end
      if (rr4) r_cycles++;
      arv4_prev = arv4;
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      address = $urandom;
      arready = 1'($urandom_range(0, 1));
      rvalid  = 1'($urandom_range(0, 1));
      rdata   = $urandom;
      rresp   = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Drives one request: arready at cycle 1+a, rvalid at cycle 2+a+b.
  // spur_k re-pulses start_i mid-transaction with spur_addr; rst_k pulses reset.
  task automatic run_txn(input int a, input int b, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp,
                         input int spur_k, input logic [31:0] spur_addr, input int rst_k);
    int tr, last_k;
    tr     = 2 + a + b;
    last_k = (tr + 2 > 8) ? tr + 2 : 8;
    t0 = cyc; ta = a; tbw = b; m_addr = addr; m_data = data; m_resp = resp;
    txn_on = 1'b1;
    rdy_cnt4 = 0; rdy_cnt8 = 0; rdy_k4 = -1; rdy_k8 = -1; rdy_err4 = 1'b0;
    ar_rise = 0; ar_cycles = 0; r_cycles = 0;
    for (int k = 0; k <= last_k; k++) begin
      start   = (k == 0) || (k == spur_k);
      address = (k == 0) ? addr : ((k == spur_k) ? spur_addr : $urandom);
      arready = (k == 1 + a) ? 1'b1 : ((k > 1 + a) ? 1'($urandom_range(0, 1)) : 1'b0);
      rvalid  = (k == tr) ? 1'b1 : ((k > tr) ? 1'($urandom_range(0, 1)) : 1'b0);
      rdata   = (k == tr) ? data : $urandom;
      rresp   = (k == tr) ? resp : 2'($urandom);
      if (k == rst_k) begin
        #2;
        rst_n = 1'b0;
        txn_on = 1'b0; last_data = '0; last_addr = '0;
        start = 1'b0; arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("rst.arvalid", 32'({arv4, arv8}), 32'd0);
        chk("rst.rready", 32'({rr4, rr8}), 32'd0);
        chk("rst.rdy", 32'({rdy4, rdy8}), 32'd0);
        chk("rst.data4", data4, 32'd0);
        chk("rst.data8", data8, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    txn_on = 1'b0;
    last_data = data;
    last_addr = {addr[31:2], 2'b00};
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // Zero-wait read.
    run_txn(0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 2'b00, -1, 32'h0, -1);
    chk("t1.rdy_k4", rdy_k4, 32'd4);
    chk("t1.rdy_k8", rdy_k8, 32'd8);
    chk("t1.data", data4, 32'hDEAD_BEEF);
    chk("t1.araddr", araddr_seen, 32'h0000_1234);
    chk("t1.err", 32'(rdy_err4), 32'd0);

    // Slow slave: arready after 5 cycles, rvalid 3 cycles after AR handshake.
    idle_cycles(2);
    run_txn(5, 2, 32'h0000_4000, 32'h1357_9BDF, 2'b00, -1, 32'h0, -1);
    chk("t2.ar_cycles", ar_cycles, 32'd6);
    chk("t2.r_cycles", r_cycles, 32'd3);
    chk("t2.rdy_k4", rdy_k4, 32'd11);
    chk("t2.rdy_k8", rdy_k8, 32'd11);
    chk("t2.rdy_cnt", rdy_cnt4 + rdy_cnt8, 32'd2);

    // Error response then a clean read.
    run_txn(0, 0, 32'h0000_0040, 32'h0BAD_F00D, 2'b10, -1, 32'h0, -1);
    chk("t4.err", 32'(rdy_err4), 32'd1);
    chk("t4.data", data8, 32'h0BAD_F00D);
    run_txn(0, 1, 32'h0000_0044, 32'h1111_2222, 2'b00, -1, 32'h0, -1);
    chk("t4.err_clear", 32'(rdy_err4), 32'd0);

    // Unaligned address and a request re-pulsed while in DATA.
    run_txn(1, 2, 32'h0000_1237, 32'hCAFE_0005, 2'b00, 3, 32'h0000_2000, -1);
    chk("t5.araddr", araddr_seen, 32'h0000_1234);
    chk("t5.ar_rise", ar_rise, 32'd1);
    chk("t5.rdy_cnt4", rdy_cnt4, 32'd1);
    chk("t5.rdy_cnt8", rdy_cnt8, 32'd1);

    // Reset while waiting in DATA abandons the transfer.
    run_txn(1, 4, 32'h0000_8000, 32'h5555_AAAA, 2'b00, -1, 32'h0, 4);
    idle_cycles(10);
    chk("t6.no_rdy", rdy_cnt4 + rdy_cnt8, 32'd0);
    run_txn(0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 2'b00, -1, 32'h0, -1);
    chk("t6.rdy_k4", rdy_k4, 32'd4);
    chk("t6.rdy_k8", rdy_k8, 32'd8);
    chk("t6.data", data4, 32'hDEAD_BEEF);

    // Randomized traffic, including back-to-back requests.
    for (int n = 0; n < 40; n++) begin
      int a, b, spur;
      a = $urandom_range(0, 4);
      b = $urandom_range(0, 4);
      spur = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + a + b) : -1;
      run_txn(a, b, $urandom, $urandom, 2'($urandom), spur, $urandom, -1);
      chk("rnd.rdy_cnt", rdy_cnt4 + rdy_cnt8, 32'd2);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
